// File: rtl/mips_bus_pkg.sv
// Shared types, address-map constants and helpers for the MIPS two-master bus arbiter.
package mips_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    localparam logic [31:0] REGION_RAM  = 32'h0000_0000;
    localparam logic [31:0] REGION_IO0  = 32'h0000_0800;
    localparam logic [31:0] REGION_IO1  = 32'h0000_0900;
    localparam logic [31:0] REGION_MASK = 32'hFFFF_FF00;

    function automatic logic is_mapped(input logic [31:0] addr);
        logic [31:0] page;
        page = addr & REGION_MASK;
        return (page == REGION_RAM) || (page == REGION_IO0) || (page == REGION_IO1);
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/mips_bus_rr_pick.sv
// Combinational 2-way round-robin chooser: a lone requester always wins, ties go to prio.
module mips_bus_rr_pick (
    input  logic [1:0] req,
    input  logic       prio,
    output logic [1:0] grant,
    output logic       winner
);

    always_comb begin
        winner = 1'b0;
        grant  = 2'b00;
        case (req)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            2'b11:   winner = prio;
            default: winner = 1'b0;
        endcase
        if (req != 2'b00)
            grant = winner ? 2'b10 : 2'b01;
    end

endmodule

// File: rtl/mips_bus_arb.sv
// Two-master round-robin arbiter for the MIPS data bus (IDLE -> ADDR -> RESP per transfer).
// Optional saturating grant/conflict counters are enabled with MIPS_BUS_ARB_STATS_EN.
module mips_bus_arb
    import mips_bus_pkg::*;
#(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int INIT_PRIO = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_a,
    input  logic [DW-1:0] m0_wd,
    output logic          m0_ack,
    output logic [DW-1:0] m0_rd,
    output logic          m0_err,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_a,
    input  logic [DW-1:0] m1_wd,
    output logic          m1_ack,
    output logic [DW-1:0] m1_rd,
    output logic          m1_err,
    output logic [AW-1:0] bus_a,
    output logic          bus_we,
    output logic [DW-1:0] bus_wd,
    input  logic [DW-1:0] bus_rd,
    output logic          owner,
    output logic [15:0]   stat_gnt0,
    output logic [15:0]   stat_gnt1,
    output logic [15:0]   stat_conflict
);

    arb_state_t    state, state_next;
    logic          prio;
    logic          err_flag;
    logic [1:0]    grant;
    logic          winner;
    logic          any_req;
    logic          sel_we;
    logic [AW-1:0] sel_a;
    logic [DW-1:0] sel_wd;
    logic          mapped;

    mips_bus_rr_pick u_pick (
        .req    ({m1_req, m0_req}),
        .prio   (prio),
        .grant  (grant),
        .winner (winner)
    );

    assign any_req = |grant;

    // Owner's request fields; masters hold them stable until their ack.
    assign sel_a  = owner ? m1_a  : m0_a;
    assign sel_wd = owner ? m1_wd : m0_wd;
    assign sel_we = owner ? m1_we : m0_we;
    assign mapped = is_mapped(32'(sel_a));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (any_req) state_next = ADDR;
            ADDR:    state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner    <= 1'(INIT_PRIO);
            prio     <= 1'(INIT_PRIO);
            err_flag <= 1'b0;
        end else begin
            case (state)
                IDLE:    if (any_req) owner <= winner;
                ADDR:    err_flag <= ~mapped;
                RESP:    prio <= ~owner;
                default: ;
            endcase
        end
    end

    // Writes to unmapped pages are suppressed; the address is still shown to the decoder.
    always_comb begin
        bus_a  = '0;
        bus_wd = '0;
        bus_we = 1'b0;
        m0_ack = 1'b0;
        m0_rd  = '0;
        m0_err = 1'b0;
        m1_ack = 1'b0;
        m1_rd  = '0;
        m1_err = 1'b0;
        case (state)
            ADDR: begin
                bus_a  = sel_a;
                bus_wd = sel_wd;
                bus_we = sel_we & mapped;
            end
            RESP: begin
                if (owner) begin
                    m1_ack = 1'b1;
                    m1_rd  = err_flag ? '0 : bus_rd;
                    m1_err = err_flag;
                end else begin
                    m0_ack = 1'b1;
                    m0_rd  = err_flag ? '0 : bus_rd;
                    m0_err = err_flag;
                end
            end
            default: ;
        endcase
    end

`ifdef MIPS_BUS_ARB_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_gnt0     <= '0;
            stat_gnt1     <= '0;
            stat_conflict <= '0;
        end else begin
            if (state == RESP && !owner)
                stat_gnt0 <= sat_inc16(stat_gnt0);
            if (state == RESP && owner)
                stat_gnt1 <= sat_inc16(stat_gnt1);
            if (state == IDLE && m0_req && m1_req)
                stat_conflict <= sat_inc16(stat_conflict);
        end
    end
`else
    assign stat_gnt0     = '0;
    assign stat_gnt1     = '0;
    assign stat_conflict = '0;
`endif

    // A master must keep its request up for the whole transfer it owns.
    a_req_held: assert property (@(posedge clk) disable iff (rst)
        (state != IDLE) |-> (owner ? m1_req : m0_req));

endmodule

// File: tb/tb_mips_bus_arb.sv
// Directed self-checking bench for mips_bus_arb (default parameters, INIT_PRIO=0).
module tb_mips_bus_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_a, m0_wd, m1_a, m1_wd;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic [31:0] m0_rd, m1_rd;
    logic [31:0] bus_a, bus_wd, bus_rd;
    logic        bus_we, owner;
    logic [15:0] stat_gnt0, stat_gnt1, stat_conflict;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mips_bus_arb dut (
        .clk           (clk),
        .rst           (rst),
        .m0_req        (m0_req),
        .m0_we         (m0_we),
        .m0_a          (m0_a),
        .m0_wd         (m0_wd),
        .m0_ack        (m0_ack),
        .m0_rd         (m0_rd),
        .m0_err        (m0_err),
        .m1_req        (m1_req),
        .m1_we         (m1_we),
        .m1_a          (m1_a),
        .m1_wd         (m1_wd),
        .m1_ack        (m1_ack),
        .m1_rd         (m1_rd),
        .m1_err        (m1_err),
        .bus_a         (bus_a),
        .bus_we        (bus_we),
        .bus_wd        (bus_wd),
        .bus_rd        (bus_rd),
        .owner         (owner),
        .stat_gnt0     (stat_gnt0),
        .stat_gnt1     (stat_gnt1),
        .stat_conflict (stat_conflict)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        m0_req = 0; m0_we = 0; m0_a = '0; m0_wd = '0;
        m1_req = 0; m1_we = 0; m1_a = '0; m1_wd = '0;
        bus_rd = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("rst_m0_ack", 32'(m0_ack), 32'd0);
        chk("rst_m1_ack", 32'(m1_ack), 32'd0);
        chk("rst_m0_rd", m0_rd, 32'd0);
        chk("rst_m0_err", 32'(m0_err), 32'd0);
        chk("rst_bus_a", bus_a, 32'd0);
        chk("rst_bus_we", 32'(bus_we), 32'd0);
        chk("rst_bus_wd", bus_wd, 32'd0);
        chk("rst_owner", 32'(owner), 32'd0);

        // Lone m0 read from RAM
        m0_req = 1; m0_we = 0; m0_a = 32'h10; bus_rd = 32'hDEADBEEF;
        tick();
        chk("rd_addr_bus_a", bus_a, 32'h10);
        chk("rd_addr_bus_we", 32'(bus_we), 32'd0);
        chk("rd_addr_m0_ack", 32'(m0_ack), 32'd0);
        tick();
        chk("rd_resp_m0_ack", 32'(m0_ack), 32'd1);
        chk("rd_resp_m0_rd", m0_rd, 32'hDEADBEEF);
        chk("rd_resp_m0_err", 32'(m0_err), 32'd0);
        chk("rd_resp_m1_ack", 32'(m1_ack), 32'd0);
        tick();
        m0_req = 0;
        chk("rd_idle_m0_ack", 32'(m0_ack), 32'd0);
        chk("rd_idle_m0_rd", m0_rd, 32'd0);

        // Short m1 pulse between edges must not be latched
        m1_req = 1; #2; m1_req = 0;
        tick();
        chk("glitch_bus_a", bus_a, 32'd0);
        tick();
        chk("glitch_m1_ack", 32'(m1_ack), 32'd0);

        // Lone m1 write to IO1
        m1_req = 1; m1_we = 1; m1_a = 32'h900; m1_wd = 32'h5; bus_rd = 32'h1234;
        tick();
        chk("wr_addr_owner", 32'(owner), 32'd1);
        chk("wr_addr_bus_we", 32'(bus_we), 32'd1);
        chk("wr_addr_bus_wd", bus_wd, 32'h5);
        chk("wr_addr_bus_a", bus_a, 32'h900);
        tick();
        chk("wr_resp_bus_we", 32'(bus_we), 32'd0);
        chk("wr_resp_m1_ack", 32'(m1_ack), 32'd1);
        chk("wr_resp_m1_err", 32'(m1_err), 32'd0);
        chk("wr_resp_m1_rd", m1_rd, 32'h1234);
        chk("wr_resp_m0_ack", 32'(m0_ack), 32'd0);
        tick();
        m1_req = 0; m1_we = 0;
        chk("wr_idle_m1_ack", 32'(m1_ack), 32'd0);

        // m0 write to unmapped page 0x400
        m0_req = 1; m0_we = 1; m0_a = 32'h400; m0_wd = 32'hAA;
        tick();
        chk("um_addr_bus_we", 32'(bus_we), 32'd0);
        chk("um_addr_bus_a", bus_a, 32'h400);
        tick();
        chk("um_resp_bus_we", 32'(bus_we), 32'd0);
        chk("um_resp_m0_ack", 32'(m0_ack), 32'd1);
        chk("um_resp_m0_err", 32'(m0_err), 32'd1);
        chk("um_resp_m0_rd", m0_rd, 32'd0);
        tick();
        m0_req = 0; m0_we = 0;
        chk("um_idle_m0_err", 32'(m0_err), 32'd0);

        // Contention held from reset: grants alternate 0,1,0,1,0,1
        rst = 1'b1;
        m0_req = 1; m0_we = 1; m0_a = 32'h10;  m0_wd = 32'h77;
        m1_req = 1; m1_we = 0; m1_a = 32'h800; m1_wd = 32'h0;
        tick();
        rst = 1'b0;
        chk("cont_rst_owner", 32'(owner), 32'd0);
        for (int t = 0; t < 6; t++) begin
            tick();
            chk($sformatf("cont%0d_owner", t), 32'(owner), 32'(t % 2));
            chk($sformatf("cont%0d_bus_we", t), 32'(bus_we), (t % 2 == 0) ? 32'd1 : 32'd0);
            tick();
            chk($sformatf("cont%0d_m0_ack", t), 32'(m0_ack), (t % 2 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("cont%0d_m1_ack", t), 32'(m1_ack), (t % 2 == 1) ? 32'd1 : 32'd0);
            tick();
            chk($sformatf("cont%0d_idle_acks", t), 32'({m1_ack, m0_ack}), 32'd0);
`ifdef MIPS_BUS_ARB_STATS_EN
            if (t == 3) begin
                chk("stat_gnt0", 32'(stat_gnt0), 32'd2);
                chk("stat_gnt1", 32'(stat_gnt1), 32'd2);
                chk("stat_conflict_ge2", 32'(stat_conflict >= 16'd2), 32'd1);
            end
`endif
        end
        m0_req = 0; m1_req = 0; m0_we = 0;
`ifndef MIPS_BUS_ARB_STATS_EN
        chk("stat_gnt0_tied", 32'(stat_gnt0), 32'd0);
        chk("stat_gnt1_tied", 32'(stat_gnt1), 32'd0);
        chk("stat_conflict_tied", 32'(stat_conflict), 32'd0);
`endif

        // Leave prio at 1 with a lone m0 transfer
        m0_req = 1; m0_a = 32'h10;
        tick(); tick(); tick();
        m0_req = 0;

        // Reset during ADDR of an m0 write
        m0_req = 1; m0_we = 1; m0_a = 32'h800; m0_wd = 32'h7;
        tick();
        chk("ra_addr_bus_we", 32'(bus_we), 32'd1);
        rst = 1'b1;
        #1;
        chk("ra_bus_we", 32'(bus_we), 32'd0);
        chk("ra_bus_a", bus_a, 32'd0);
        chk("ra_bus_wd", bus_wd, 32'd0);
        chk("ra_m0_ack", 32'(m0_ack), 32'd0);
        m1_req = 1; m1_we = 0; m1_a = 32'h900;
        tick();
        chk("ra_hold_m0_ack", 32'(m0_ack), 32'd0);
        rst = 1'b0;
        tick();
        chk("ra_next_owner", 32'(owner), 32'd0);
        tick();
        chk("ra_next_m0_ack", 32'(m0_ack), 32'd1);
        tick();
        m0_req = 0; m0_we = 0;
        tick();
        chk("ra_then_owner", 32'(owner), 32'd1);
        tick();
        chk("ra_then_m1_ack", 32'(m1_ack), 32'd1);
        tick();
        m1_req = 0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
